checkpoint_seq_monitor: RTL and testbench
=========================================

# checkpoint_seq_monitor

Parametrised checkpoint-sequence monitor for the Caravel user-project benches and on-chip self-test. It watches a GPIO checkpoint bus (firmware markers such as 0x00A5 "test started" and 0x4AA6 "test passed") and checks that a programmable, ordered list of markers appears. Each marker must be stable for a minimum number of cycles, and must arrive within a per-checkpoint timeout. The result is reported as sticky pass/fail with a failure code and a checkpoint index.

## Interface
Parameters:
- DW, 16, checkpoint bus width
- NCHK, 8, depth of the expected-marker table (>=2)
- TW, 24, timeout counter width
- STABLE_CYC, 2, consecutive identical samples required to qualify a marker (>=1)
- STRICT, 1, 1 = an out-of-order marker is a failure; 0 = out-of-order markers are ignored

Ports:
- clock  in  1  single clock for the block
- reset  in  1  asynchronous, active-high reset
- chk_in  in  DW  checkpoint bus (mprj_io[31:16] in the standard harness)
- exp_wr  in  1  table write strobe; honoured only in IDLE
- exp_idx  in  $clog2(NCHK)  table write address
- exp_data  in  DW  table write data
- num_chk  in  $clog2(NCHK)+1  number of checkpoints to check, valid range 1..NCHK
- timeout_limit  in  TW  per-checkpoint cycle budget; 0 disables the timeout
- start  in  1  one-cycle arm pulse
- clear  in  1  return from PASS/FAIL to IDLE
- busy  out  1  high in WAIT
- hit  out  1  one-cycle pulse per matched checkpoint
- cur_idx  out  $clog2(NCHK)  index of the next expected checkpoint
- pass  out  1  sticky, high in PASS
- fail  out  1  sticky, high in FAIL
- fail_code  out  2  0 none, 1 timeout, 2 out-of-order, 3 bad num_chk

## Operation
- Reset values:
  - State is IDLE.
  - All table entries, busy, hit, cur_idx, pass, fail and fail_code are 0.
  - s_q and run are 0.
  - The timer is 0.
- Qualifier, always running:
  - s_q <= chk_in on every edge.
  - run <= 1 if chk_in != s_q; otherwise run <= min(run+1, STABLE_CYC).
  - qual = (run == STABLE_CYC) & !consumed.
  - consumed is set on a hit or on an ignored out-of-order match. It is cleared whenever run reloads to 1.
  - Each qualified value is therefore evaluated at most once. An expected value that repeats in the table must change and then return on the bus to match again.
- States:
  - IDLE: exp_wr writes exp[exp_idx] <= exp_data. On start:
    - if num_chk is 0 or greater than NCHK, go to FAIL with code 3;
    - otherwise go to WAIT with cur_idx = 0 and timer = 0.
  - WAIT:
    - The timer increments every cycle.
    - If qual and s_q == exp[cur_idx], this is a hit: pulse hit, set consumed and clear the timer. If cur_idx == num_chk-1, go to PASS; otherwise cur_idx increments.
    - Else if qual and s_q == exp[j] for some cur_idx < j < num_chk: with STRICT = 1, go to FAIL with code 2; with STRICT = 0, set consumed and stay in WAIT.
    - Else if timeout_limit != 0 and timer == timeout_limit-1, go to FAIL with code 1.
    - Qualified values that match no table entry are ignored.
  - PASS / FAIL: outputs hold. clear returns to IDLE and zeroes pass, fail, fail_code and cur_idx. The table is retained.
- Precedence:
  - In WAIT, a hit beats an out-of-order match, which beats a timeout in the same cycle.
  - start outside IDLE is ignored; exp_wr outside IDLE is ignored.
  - clear in IDLE or WAIT is ignored.
- Asserting reset mid-run forces IDLE immediately and clears the table.

## Timing
- Marker latency: a value first sampled at edge t (present before edge t, held afterwards) qualifies after edge t+STABLE_CYC-1. hit is high for the cycle after edge t+STABLE_CYC. cur_idx updates on that same edge.
- A glitch shorter than STABLE_CYC cycles never qualifies. It also restarts run for the value it interrupted.
- Timeout: with no hit, FAIL is entered exactly timeout_limit cycles after entering WAIT or after the last hit.
- pass and fail assert on the same edge as the state transition, with zero extra latency.
- Table reads are combinational from registers. There is no read latency.

## Test plan
- Basic pass: table {0x00A5, 0x4AA6}, num_chk = 2, STABLE_CYC = 2, timeout = 1000, each marker held 5 cycles -> two hit pulses, each 2 cycles after first sample; pass = 1, fail_code = 0.
- Glitch rejection: drive 0x00A5 for 1 cycle, then 0 -> no hit, cur_idx stays 0. A later 3-cycle 0x00A5 -> hit.
- Timeout: table {0x00A5}, timeout_limit = 50, chk_in held at 0 -> fail = 1, code 1, exactly 50 cycles after start. Repeat with timeout_limit = 0 and 10000 idle cycles -> still busy.
- Ordering: table {1, 2, 3}, drive 2 first -> STRICT = 1 gives FAIL code 2 with cur_idx = 0. STRICT = 0 ignores it, then 1, 2, 3 -> pass.
- Repeated entry: table {0x55, 0x55}; holding 0x55 for 20 cycles -> exactly one hit. Going 0x55 -> 0 -> 0x55 -> second hit, then pass.
- Boundaries:
  - num_chk = 0 on start -> FAIL code 3 next cycle.
  - Hit and timeout in the same cycle -> hit wins.
  - reset during WAIT -> all outputs 0 and the table reads 0.
  - num_chk = NCHK full run -> pass.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint-sequence monitor: qualifies stable markers on a GPIO checkpoint bus and
// checks them against a programmable ordered table, with per-checkpoint timeout.
module checkpoint_seq_monitor #(
  parameter int DW         = 16,
  parameter int NCHK       = 8,
  parameter int TW         = 24,
  parameter int STABLE_CYC = 2,
  parameter int STRICT     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DW-1:0]           chk_in,
  input  logic                    exp_wr,
  input  logic [$clog2(NCHK)-1:0] exp_idx,
  input  logic [DW-1:0]           exp_data,
  input  logic [$clog2(NCHK):0]   num_chk,
  input  logic [TW-1:0]           timeout_limit,
  input  logic                    start,
  input  logic                    clear,
  output logic                    busy,
  output logic                    hit,
  output logic [$clog2(NCHK)-1:0] cur_idx,
  output logic                    pass,
  output logic                    fail,
  output logic [1:0]              fail_code
);
  localparam int IW = $clog2(NCHK);
  localparam int CW = IW + 1;
  localparam int RW = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_exp [NCHK];
  logic [DW-1:0]   r_s_q;
  logic [RW-1:0]   r_run;
  logic            r_consumed;
  logic [TW-1:0]   r_timer;
  logic            r_busy;
  logic            r_hit;
  logic [IW-1:0]   r_cur_idx;
  logic            r_pass;
  logic            r_fail;
  logic [1:0]      r_fail_code;

  logic [NCHK-1:0] w_ooo;
  logic            w_in_wait;
  logic            w_qual;
  logic            w_hit;
  logic            w_ooo_any;
  logic            w_last;
  logic            w_tmo;
  logic            w_bad_num;

  assign w_in_wait = (r_state == S_WAIT);

  // Per-entry table storage and "later entry matches" detection.
  for (genvar gi = 0; gi < NCHK; gi++) begin : g_entry
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        r_exp[gi] <= '0;
      else if (r_state == S_IDLE && exp_wr && exp_idx == IW'(gi))
        r_exp[gi] <= exp_data;
    end

    assign w_ooo[gi] = (r_exp[gi] == r_s_q) && (IW'(gi) > r_cur_idx) &&
                       (CW'(gi) < num_chk);
  end

  assign w_qual    = (r_run == RW'(STABLE_CYC)) && !r_consumed;
  assign w_hit     = w_in_wait && w_qual && (r_exp[r_cur_idx] == r_s_q);
  assign w_ooo_any = w_in_wait && w_qual && (|w_ooo);
  assign w_last    = ({1'b0, r_cur_idx} == (num_chk - CW'(1)));
  assign w_tmo     = (timeout_limit != '0) && (r_timer == (timeout_limit - TW'(1)));
  assign w_bad_num = (num_chk == '0) || (num_chk > CW'(NCHK));

  // A bus change restarts the stability run and re-arms evaluation, even if a
  // hit lands on the same edge (the hit belonged to the previous value).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s_q      <= '0;
      r_run      <= '0;
      r_consumed <= 1'b0;
    end else begin
      r_s_q <= chk_in;
      if (chk_in != r_s_q) begin
        r_run      <= RW'(1);
        r_consumed <= 1'b0;
      end else begin
        if (r_run != RW'(STABLE_CYC))
          r_run <= r_run + RW'(1);
        if (w_hit || (w_ooo_any && STRICT == 0))
          r_consumed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_hit       <= 1'b0;
      r_cur_idx   <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 2'd0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad_num) begin
              r_state     <= S_FAIL;
              r_fail      <= 1'b1;
              r_fail_code <= 2'd3;
            end else begin
              r_state   <= S_WAIT;
              r_busy    <= 1'b1;
              r_cur_idx <= '0;
              r_timer   <= '0;
            end
          end
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (w_hit) begin
            r_hit   <= 1'b1;
            r_timer <= '0;
            if (w_last) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cur_idx <= r_cur_idx + IW'(1);
            end
          end else if (w_ooo_any && STRICT != 0) begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_code <= 2'd2;
            r_busy      <= 1'b0;
          end else if (w_tmo) begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_code <= 2'd1;
            r_busy      <= 1'b0;
          end
        end
        S_PASS, S_FAIL: begin
          if (clear) begin
            r_state     <= S_IDLE;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= 2'd0;
            r_cur_idx   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign hit       = r_hit;
  assign cur_idx   = r_cur_idx;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed bench for checkpoint_seq_monitor: a STRICT=1 and a STRICT=0 instance share stimulus.
module tb_checkpoint_seq_monitor;
  logic        clk, rst;
  logic [15:0] chk_in, exp_data;
  logic        exp_wr, start, clear;
  logic [2:0]  exp_idx;
  logic [3:0]  num_chk;
  logic [23:0] timeout_limit;
  logic        s_busy, s_hit, s_pass, s_fail;
  logic [2:0]  s_cur_idx;
  logic [1:0]  s_fail_code;
  logic        n_busy, n_hit, n_pass, n_fail;
  logic [2:0]  n_cur_idx;
  logic [1:0]  n_fail_code;
  int          passed = 0;
  int          total  = 0;

  checkpoint_seq_monitor #(.STRICT(1)) u_strict (
    .clock(clk), .reset(rst), .chk_in(chk_in), .exp_wr(exp_wr), .exp_idx(exp_idx),
    .exp_data(exp_data), .num_chk(num_chk), .timeout_limit(timeout_limit),
    .start(start), .clear(clear), .busy(s_busy), .hit(s_hit), .cur_idx(s_cur_idx),
    .pass(s_pass), .fail(s_fail), .fail_code(s_fail_code));

  checkpoint_seq_monitor #(.STRICT(0)) u_loose (
    .clock(clk), .reset(rst), .chk_in(chk_in), .exp_wr(exp_wr), .exp_idx(exp_idx),
    .exp_data(exp_data), .num_chk(num_chk), .timeout_limit(timeout_limit),
    .start(start), .clear(clear), .busy(n_busy), .hit(n_hit), .cur_idx(n_cur_idx),
    .pass(n_pass), .fail(n_fail), .fail_code(n_fail_code));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] data);
    exp_wr = 1'b1; exp_idx = idx; exp_data = data;
    step(1);
    exp_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic test_reset();
    step(3);
    total++; if (s_busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", s_busy); else passed++;
    total++; if (s_pass !== 1'b0 || s_fail !== 1'b0) $display("FAIL reset_passfail got=%0b%0b exp=00", s_pass, s_fail); else passed++;
    total++; if (s_cur_idx !== 3'd0 || s_fail_code !== 2'd0 || s_hit !== 1'b0) $display("FAIL reset_idx_code got=%0d/%0d/%0b exp=0/0/0", s_cur_idx, s_fail_code, s_hit); else passed++;
    rst = 1'b0;
    step(3);
    total++; if (s_busy !== 1'b0 || n_busy !== 1'b0) $display("FAIL post_reset_idle got=%0b%0b exp=00", s_busy, n_busy); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    wr(0, 16'h00A5); wr(1, 16'h4AA6);
    num_chk = 4'd2; timeout_limit = 24'd1000;
    pulse_start();
    total++; if (s_busy !== 1'b1) $display("FAIL basic_busy got=%0b exp=1", s_busy); else passed++;
    chk_in = 16'h00A5;
    step(2);
    total++; if (s_hit !== 1'b0) $display("FAIL basic_early_hit got=%0b exp=0", s_hit); else passed++;
    step(1);
    total++; if (s_hit !== 1'b1 || s_cur_idx !== 3'd1) $display("FAIL basic_hit1 got=%0b/%0d exp=1/1", s_hit, s_cur_idx); else passed++;
    step(1);
    total++; if (s_hit !== 1'b0) $display("FAIL basic_hit_pulse got=%0b exp=0", s_hit); else passed++;
    step(1);
    chk_in = 16'h4AA6;
    step(2);
    total++; if (s_hit !== 1'b0 || s_pass !== 1'b0) $display("FAIL basic_early2 got=%0b/%0b exp=0/0", s_hit, s_pass); else passed++;
    step(1);
    total++; if (s_hit !== 1'b1 || s_pass !== 1'b1 || s_busy !== 1'b0) $display("FAIL basic_pass got=%0b/%0b/%0b exp=1/1/0", s_hit, s_pass, s_busy); else passed++;
    total++; if (s_fail !== 1'b0 || s_fail_code !== 2'd0 || s_cur_idx !== 3'd1) $display("FAIL basic_code got=%0b/%0d/%0d exp=0/0/1", s_fail, s_fail_code, s_cur_idx); else passed++;
    chk_in = 16'h0000;
    step(3);
    total++; if (s_pass !== 1'b1) $display("FAIL basic_sticky got=%0b exp=1", s_pass); else passed++;
    pulse_clear();
    total++; if (s_pass !== 1'b0 || s_cur_idx !== 3'd0) $display("FAIL basic_clear got=%0b/%0d exp=0/0", s_pass, s_cur_idx); else passed++;
    $display("test_basic done");
  endtask

  task automatic test_glitch();
    int hs = 0;
    pulse_start();
    chk_in = 16'h00A5;
    step(1);
    chk_in = 16'h0000;
    for (int i = 0; i < 4; i++) begin step(1); if (s_hit) hs++; end
    total++; if (hs != 0 || s_cur_idx !== 3'd0) $display("FAIL glitch_reject got=%0d/%0d exp=0/0", hs, s_cur_idx); else passed++;
    chk_in = 16'h00A5;
    step(3);
    total++; if (s_hit !== 1'b1 || s_cur_idx !== 3'd1) $display("FAIL glitch_later_hit got=%0b/%0d exp=1/1", s_hit, s_cur_idx); else passed++;
    chk_in = 16'h4AA6;
    step(3);
    total++; if (s_pass !== 1'b1) $display("FAIL glitch_pass got=%0b exp=1", s_pass); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_glitch done");
  endtask

  task automatic test_timeout();
    num_chk = 4'd1; timeout_limit = 24'd50;
    pulse_start();
    step(49);
    total++; if (s_fail !== 1'b0 || s_busy !== 1'b1) $display("FAIL tmo_early got=%0b/%0b exp=0/1", s_fail, s_busy); else passed++;
    step(1);
    total++; if (s_fail !== 1'b1 || s_fail_code !== 2'd1 || s_busy !== 1'b0) $display("FAIL tmo_fire got=%0b/%0d/%0b exp=1/1/0", s_fail, s_fail_code, s_busy); else passed++;
    pulse_clear();
    timeout_limit = 24'd0;
    pulse_start();
    step(10000);
    total++; if (s_busy !== 1'b1 || s_fail !== 1'b0) $display("FAIL tmo_disabled got=%0b/%0b exp=1/0", s_busy, s_fail); else passed++;
    chk_in = 16'h00A5;
    step(3);
    total++; if (s_pass !== 1'b1) $display("FAIL tmo_disabled_pass got=%0b exp=1", s_pass); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_timeout done");
  endtask

  task automatic test_ordering();
    wr(0, 16'd1); wr(1, 16'd2); wr(2, 16'd3);
    num_chk = 4'd3; timeout_limit = 24'd1000;
    pulse_start();
    chk_in = 16'd2;
    step(3);
    total++; if (s_fail !== 1'b1 || s_fail_code !== 2'd2 || s_cur_idx !== 3'd0) $display("FAIL order_strict got=%0b/%0d/%0d exp=1/2/0", s_fail, s_fail_code, s_cur_idx); else passed++;
    total++; if (n_fail !== 1'b0 || n_busy !== 1'b1 || n_hit !== 1'b0) $display("FAIL order_loose_ignore got=%0b/%0b/%0b exp=0/1/0", n_fail, n_busy, n_hit); else passed++;
    chk_in = 16'd1; step(3);
    total++; if (n_hit !== 1'b1 || n_cur_idx !== 3'd1) $display("FAIL order_loose_h1 got=%0b/%0d exp=1/1", n_hit, n_cur_idx); else passed++;
    chk_in = 16'd2; step(3);
    total++; if (n_hit !== 1'b1 || n_cur_idx !== 3'd2) $display("FAIL order_loose_h2 got=%0b/%0d exp=1/2", n_hit, n_cur_idx); else passed++;
    chk_in = 16'd3; step(3);
    total++; if (n_pass !== 1'b1 || n_fail !== 1'b0) $display("FAIL order_loose_pass got=%0b/%0b exp=1/0", n_pass, n_fail); else passed++;
    total++; if (s_fail_code !== 2'd2 || s_pass !== 1'b0) $display("FAIL order_strict_hold got=%0d/%0b exp=2/0", s_fail_code, s_pass); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_ordering done");
  endtask

  task automatic test_repeat();
    int hs = 0;
    wr(0, 16'h0055); wr(1, 16'h0055);
    num_chk = 4'd2; timeout_limit = 24'd1000;
    pulse_start();
    chk_in = 16'h0055;
    for (int i = 0; i < 20; i++) begin step(1); if (s_hit) hs++; end
    total++; if (hs != 1 || s_cur_idx !== 3'd1 || s_pass !== 1'b0) $display("FAIL repeat_once got=%0d/%0d/%0b exp=1/1/0", hs, s_cur_idx, s_pass); else passed++;
    chk_in = 16'h0000; step(2);
    chk_in = 16'h0055; step(2);
    total++; if (s_hit !== 1'b0) $display("FAIL repeat_early got=%0b exp=0", s_hit); else passed++;
    step(1);
    total++; if (s_hit !== 1'b1 || s_pass !== 1'b1) $display("FAIL repeat_second got=%0b/%0b exp=1/1", s_hit, s_pass); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_repeat done");
  endtask

  task automatic test_bad_num();
    num_chk = 4'd0;
    pulse_start();
    total++; if (s_fail !== 1'b1 || s_fail_code !== 2'd3 || s_busy !== 1'b0) $display("FAIL badnum_zero got=%0b/%0d/%0b exp=1/3/0", s_fail, s_fail_code, s_busy); else passed++;
    pulse_clear();
    total++; if (s_fail !== 1'b0 || s_fail_code !== 2'd0) $display("FAIL badnum_clear got=%0b/%0d exp=0/0", s_fail, s_fail_code); else passed++;
    num_chk = 4'd9;
    pulse_start();
    total++; if (s_fail !== 1'b1 || s_fail_code !== 2'd3) $display("FAIL badnum_big got=%0b/%0d exp=1/3", s_fail, s_fail_code); else passed++;
    pulse_clear();
    $display("test_bad_num done");
  endtask

  task automatic test_hit_vs_timeout();
    wr(0, 16'h00A5); wr(1, 16'h4AA6);
    num_chk = 4'd2; timeout_limit = 24'd3;
    pulse_start();
    chk_in = 16'h00A5;
    step(3);
    total++; if (s_hit !== 1'b1 || s_fail !== 1'b0 || s_busy !== 1'b1 || s_cur_idx !== 3'd1) $display("FAIL hit_beats_tmo got=%0b/%0b/%0b/%0d exp=1/0/1/1", s_hit, s_fail, s_busy, s_cur_idx); else passed++;
    step(2);
    total++; if (s_fail !== 1'b0) $display("FAIL tmo_after_hit_early got=%0b exp=0", s_fail); else passed++;
    step(1);
    total++; if (s_fail !== 1'b1 || s_fail_code !== 2'd1) $display("FAIL tmo_after_hit got=%0b/%0d exp=1/1", s_fail, s_fail_code); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_hit_vs_timeout done");
  endtask

  task automatic test_reset_mid();
    wr(0, 16'h00A5);
    num_chk = 4'd1; timeout_limit = 24'd0;
    pulse_start();
    step(3);
    total++; if (s_busy !== 1'b1) $display("FAIL rmid_busy got=%0b exp=1", s_busy); else passed++;
    rst = 1'b1;
    #2;
    total++; if (s_busy !== 1'b0 || s_cur_idx !== 3'd0 || s_pass !== 1'b0 || s_fail !== 1'b0) $display("FAIL rmid_async got=%0b/%0d/%0b/%0b exp=0/0/0/0", s_busy, s_cur_idx, s_pass, s_fail); else passed++;
    step(2);
    rst = 1'b0;
    step(3);
    pulse_start();
    step(1);
    total++; if (s_hit !== 1'b1 || s_pass !== 1'b1) $display("FAIL rmid_table_zero got=%0b/%0b exp=1/1", s_hit, s_pass); else passed++;
    pulse_clear();
    $display("test_reset_mid done");
  endtask

  task automatic test_full();
    logic [2:0] want;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h0100 + 16'(i));
    num_chk = 4'd8; timeout_limit = 24'd1000;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      chk_in = 16'h0100 + 16'(i);
      step(3);
      want = (i == 7) ? 3'd7 : 3'(i + 1);
      total++; if (s_hit !== 1'b1 || s_cur_idx !== want) $display("FAIL full_hit%0d got=%0b/%0d exp=1/%0d", i, s_hit, s_cur_idx, want); else passed++;
    end
    total++; if (s_pass !== 1'b1 || n_pass !== 1'b1 || s_fail !== 1'b0) $display("FAIL full_pass got=%0b/%0b/%0b exp=1/1/0", s_pass, n_pass, s_fail); else passed++;
    chk_in = 16'h0000; step(2); pulse_clear();
    $display("test_full done");
  endtask

  initial begin
    rst = 1'b1; chk_in = '0; exp_wr = 1'b0; exp_idx = '0; exp_data = '0;
    num_chk = '0; timeout_limit = '0; start = 1'b0; clear = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_ordering();
    test_repeat();
    test_bad_num();
    test_hit_vs_timeout();
    test_reset_mid();
    test_full();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
